pipeline_hazard_ctrl: RTL

Central stall/flush controller for the 5-stage RISC-V pipeline. It generates the write enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and sequences the data-memory req/ack handshake for the instruction in the MEM stage. It resolves load-use hazards, taken branches, multi-cycle memory waits and memory timeout. At top level, each `*_flush` output is ORed with global `reset` onto the matching pipeline register's synchronous reset pin.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 12 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch,
// data-memory req/ack sequencing with timeout, and performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  ex_mem_memread,
    input  logic                  ex_mem_memwrite,
    input  logic                  ex_mem_branch,
    input  logic                  ex_mem_zero,
    input  logic                  dmem_ack,
    output logic                  dmem_req,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  mem_wb_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic                  dmem_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic memop, taken, luse;
    logic freeze, resolve;
    logic stall_inc, flush_inc;

    assign memop = ex_mem_memread | ex_mem_memwrite;
    assign taken = ex_mem_branch & ex_mem_zero;
    assign luse  = id_ex_memread && (id_ex_rd != '0) &&
                   ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dmem_req     = 1'b0;
        pc_write     = 1'b1;
        pc_src       = 1'b0;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        dmem_timeout = 1'b0;
        freeze       = 1'b0;
        resolve      = 1'b0;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            state_d      = RUN;
            wait_cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    dmem_req = memop;
                    if (memop && !dmem_ack) begin
                        freeze     = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = '0;
                    end else begin
                        resolve = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    // ack wins over timeout on the final wait cycle
                    if (dmem_ack) begin
                        resolve = 1'b1;
                        state_d = RUN;
                    end else begin
                        freeze     = 1'b1;
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d = ERROR;
                        end
                    end
                end
                ERROR: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_write = 1'b0;
                    dmem_timeout = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            if (freeze) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (resolve) begin
                if (taken) begin
                    pc_src       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (luse) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    assign stall_inc = !reset && !pc_write && ((state_q == RUN) || (state_q == MEM_WAIT));
    assign flush_inc = !reset && resolve && taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
